// File: rtl/vec_issue.sv
// ---------------------------------------------------------------------------
// vec_issue
//   Single-issue sequencer for a combinational vector unit. Holds a small
//   vector register file that the host fills through a load port, accepts one
//   instruction at a time, presents operands to the vector unit for the
//   instruction's latency, then writes the unit's result back to the
//   destination register.
//
//   FSM: IDLE -> EXEC (lat cycles) -> WRITE (1 cycle) -> IDLE.
//   Loads are only accepted in IDLE, so operands stay stable while busy.
//
// Ports
//   clock, reset_n        clock, synchronous active-low reset
//   instr_valid/ready     instruction handshake
//   instr_op/rd/rs1/rs2   op code and register indices
//   instr_imm             32-bit scalar for the vector unit (vu_inK)
//   ld_valid/ready        host register-load handshake
//   ld_addr/ld_data       load target register and vector data
//   rd_addr/rd_data       combinational register read-back
//   vu_op/in1/in2/inK     operands driven to the vector unit
//   vu_out                combinational vector-unit result
//   busy                  high whenever the FSM is not IDLE
//   done                  high during the WRITE cycle
// ---------------------------------------------------------------------------
module vec_issue #(
   parameter  int WIDTH     = 128,
   parameter  int NUM_REGS  = 8,
   parameter  int ARITH_LAT = 1,
   parameter  int ACT_LAT   = 4,
   localparam int AW        = $clog2(NUM_REGS),
   localparam int MAXLAT    = (ARITH_LAT > ACT_LAT) ? ARITH_LAT : ACT_LAT,
   localparam int CW        = $clog2(MAXLAT) + 1,
   localparam int DW        = WIDTH * 32
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_rs1,
   input  logic [AW-1:0] instr_rs2,
   input  logic [31:0]   instr_imm,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [2:0]    vu_op,
   output logic [DW-1:0] vu_in1,
   output logic [DW-1:0] vu_in2,
   output logic [31:0]   vu_inK,
   input  logic [DW-1:0] vu_out,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q;
   logic [AW-1:0]   rd_q, rs1_q, rs2_q;
   logic [31:0]     imm_q;
   logic [DW-1:0]   regs_q [NUM_REGS];

   logic            instr_fire;
   logic            ld_fire;

   // Activation ops (5..7) use the longer latency; the counter holds lat-1.
   function automatic logic [CW-1:0] lat_m1(input logic [2:0] op);
      return (op >= 3'd5) ? CW'(ACT_LAT - 1) : CW'(ARITH_LAT - 1);
   endfunction

   assign instr_fire = instr_valid && instr_ready;
   assign ld_fire    = ld_valid && ld_ready;

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (instr_fire) begin
               state_d = S_EXEC;
               cnt_d   = lat_m1(instr_op);
            end
         end
         S_EXEC: begin
            if (cnt_q == '0) state_d = S_WRITE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: a pending load blocks instruction acceptance in IDLE.
   always_comb begin
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_WRITE);
      ld_ready    = (state_q == S_IDLE);
      instr_ready = (state_q == S_IDLE) && !ld_valid;
   end

   // Instruction latches and register file. Loads and the WRITE-cycle
   // write-back can never coincide because loads need IDLE.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         op_q  <= '0;
         rd_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         imm_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         if (instr_fire) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            imm_q <= instr_imm;
         end
         if (ld_fire)            regs_q[ld_addr] <= ld_data;
         if (state_q == S_WRITE) regs_q[rd_q]    <= vu_out;
      end
   end

   assign vu_op   = op_q;
   assign vu_inK  = imm_q;
   assign vu_in1  = regs_q[rs1_q];
   assign vu_in2  = regs_q[rs2_q];
   assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_vec_issue.sv
// ---------------------------------------------------------------------------
// tb_vec_issue
//   Bench for vec_issue with a behavioural vector unit (real arithmetic on
//   IEEE-754 singles). Issued instructions push their expected destination
//   value onto a scoreboard; the value is popped and compared when done fires.
// ---------------------------------------------------------------------------
module tb_vec_issue;

   localparam int W  = 4;
   localparam int NR = 8;
   localparam int AL = 1;
   localparam int TL = 4;
   localparam int VW = W * 32;

   typedef logic [VW-1:0] vec_t;

   localparam logic [31:0] F0   = 32'h0000_0000;
   localparam logic [31:0] F0P5 = 32'h3F00_0000;
   localparam logic [31:0] F1   = 32'h3F80_0000;
   localparam logic [31:0] F1P5 = 32'h3FC0_0000;
   localparam logic [31:0] F2   = 32'h4000_0000;
   localparam logic [31:0] F2P5 = 32'h4020_0000;
   localparam logic [31:0] F3   = 32'h4040_0000;
   localparam logic [31:0] F3P5 = 32'h4060_0000;
   localparam logic [31:0] F4   = 32'h4080_0000;
   localparam logic [31:0] F5   = 32'h40A0_0000;
   localparam logic [31:0] F6   = 32'h40C0_0000;
   localparam logic [31:0] F7   = 32'h40E0_0000;
   localparam logic [31:0] F9   = 32'h4110_0000;
   localparam logic [31:0] FM2  = 32'hC000_0000;
   localparam logic [31:0] FM3  = 32'hC040_0000;
   localparam logic [31:0] FM6  = 32'hC0C0_0000;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       instr_valid, instr_ready;
   logic [2:0] instr_op, instr_rd, instr_rs1, instr_rs2;
   logic [31:0] instr_imm;
   logic       ld_valid, ld_ready;
   logic [2:0] ld_addr;
   vec_t       ld_data;
   logic [2:0] rd_addr;
   vec_t       rd_data;
   logic [2:0] vu_op;
   vec_t       vu_in1, vu_in2, vu_out;
   logic [31:0] vu_inK;
   logic       busy, done;

   always #5 clock = ~clock;

   vec_issue #(
      .WIDTH(W), .NUM_REGS(NR), .ARITH_LAT(AL), .ACT_LAT(TL)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd),
      .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .vu_op(vu_op), .vu_in1(vu_in1), .vu_in2(vu_in2), .vu_inK(vu_inK),
      .vu_out(vu_out), .busy(busy), .done(done)
   );

   // ---------------- float helpers and vector-unit model ----------------
   function automatic real f2r(input logic [31:0] f);
      if (f[30:23] == 8'h00) return 0.0;
      return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = d[62:52];
      return {d[63], 8'(e - 11'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] vu_lane(input logic [2:0] op,
                                           input logic [31:0] a, b, k);
      real x, y, s, r, e2;
      x = f2r(a); y = f2r(b); s = f2r(k);
      case (op)
         3'd0: r = x + y;
         3'd1: r = x - y;
         3'd2: r = x * y;
         3'd3: r = x * s;
         3'd4: r = (x - y) * s;
         3'd5: r = 1.0 / (1.0 + $exp(-x));
         3'd6: begin e2 = $exp(2.0 * x); r = (e2 - 1.0) / (e2 + 1.0); end
         default: r = (x > 0.0) ? x : 0.0;
      endcase
      return r2f(r);
   endfunction

   always_comb begin
      vu_out = '0;
      for (int l = 0; l < W; l++)
         vu_out[l*32 +: 32] = vu_lane(vu_op, vu_in1[l*32 +: 32], vu_in2[l*32 +: 32], vu_inK);
   end

   function automatic vec_t splat(input logic [31:0] x);
      vec_t v;
      for (int l = 0; l < W; l++) v[l*32 +: 32] = x;
      return v;
   endfunction

   function automatic int lat_of(input logic [2:0] op);
      return (op >= 3'd5) ? TL : AL;
   endfunction

   // ---------------- shadow register file and scoreboard ----------------
   vec_t mreg [NR];

   typedef struct {
      logic [2:0] rd;
      vec_t       val;
   } sb_t;
   sb_t sbq[$];

   function automatic vec_t model(input logic [2:0] op, rs1, rs2,
                                  input logic [31:0] imm);
      vec_t v;
      for (int l = 0; l < W; l++)
         v[l*32 +: 32] = vu_lane(op, mreg[rs1][l*32 +: 32], mreg[rs2][l*32 +: 32], imm);
      return v;
   endfunction

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input vec_t act, input vec_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- stimulus tasks ----------------
   task automatic do_load(input logic [2:0] a, input vec_t v);
      int n;
      @(negedge clock);
      ld_valid = 1'b1; ld_addr = a; ld_data = v;
      #1; n = 0;
      while (!ld_ready && n < 50) begin @(negedge clock); #1; n++; end
      chk("ld_accept", vec_t'(ld_ready), vec_t'(1));
      if (ld_ready) begin
         @(posedge clock); #1;
         mreg[a] = v;
      end
      ld_valid = 1'b0;
   endtask

   // Called at a negedge; returns just after the accepting edge (edge 0).
   task automatic offer(input logic [2:0] op, rd, rs1, rs2,
                        input logic [31:0] imm, output int n);
      sb_t e;
      instr_valid = 1'b1; instr_op = op; instr_rd = rd;
      instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
      #1; n = 0;
      while (!instr_ready && n < 50) begin @(negedge clock); #1; n++; end
      if (!instr_ready) begin
         checks++; failures++;
         $display("FAIL offer_timeout actual=0 required=1");
         instr_valid = 1'b0;
         return;
      end
      @(posedge clock);
      e.rd = rd; e.val = model(op, rs1, rs2, imm);
      sbq.push_back(e);
      #1; instr_valid = 1'b0;
   endtask

   // Called right after edge 0; follows EXEC/WRITE and checks the write-back.
   task automatic wait_done(input int lat, input string nm);
      int  k;
      bit  ctl_ok;
      sb_t e;
      k = 0; ctl_ok = 1'b1;
      @(negedge clock); #1;
      while (!done && k < 20) begin
         if (!busy || instr_ready || ld_ready) ctl_ok = 1'b0;
         k++; @(negedge clock); #1;
      end
      chk({nm, "_exec_ctl"}, vec_t'(ctl_ok), vec_t'(1));
      chk({nm, "_lat"}, vec_t'(k), vec_t'(lat));
      if (!done) return;
      chk({nm, "_write_ctl"}, vec_t'({busy, instr_ready, ld_ready}), vec_t'(3'b100));
      if (sbq.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s_sb_empty actual=0 required=1", nm);
         return;
      end
      e = sbq.pop_front();
      mreg[e.rd] = e.val;
      rd_addr = e.rd;
      @(negedge clock); #1;
      chk({nm, "_wb"}, rd_data, e.val);
      chk({nm, "_done_fall"}, vec_t'(done), vec_t'(0));
   endtask

   task automatic run(input logic [2:0] op, rd, rs1, rs2,
                      input logic [31:0] imm, input string nm);
      int n;
      @(negedge clock);
      offer(op, rd, rs1, rs2, imm, n);
      wait_done(lat_of(op), nm);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0]  la;  logic [31:0] lv;
      logic [2:0]  lb;  logic [31:0] lw;
      logic [2:0]  op, rd, rs1, rs2;
      logic [31:0] imm, exp;
   } rec_t;

   rec_t tbl [9];

   initial begin
      int   n, n2;
      bit   ok;
      string nm;

      tbl[0] = '{3'd1, F1P5, 3'd2, F2,   3'd0, 3'd3, 3'd1, 3'd2, F0,  F3P5};
      tbl[1] = '{3'd1, F0,   3'd2, F0,   3'd5, 3'd4, 3'd1, 3'd2, F0,  F0P5};
      tbl[2] = '{3'd1, F3,   3'd2, F4,   3'd3, 3'd1, 3'd1, 3'd2, FM2, FM6};
      tbl[3] = '{3'd2, F4,   3'd3, F1,   3'd1, 3'd2, 3'd2, 3'd3, F0,  F3};
      tbl[4] = '{3'd5, FM3,  3'd6, F2,   3'd7, 3'd7, 3'd5, 3'd6, F0,  F0};
      tbl[5] = '{3'd0, F2,   3'd1, F1P5, 3'd2, 3'd0, 3'd0, 3'd1, F0,  F3};
      tbl[6] = '{3'd2, F2,   3'd3, F0P5, 3'd4, 3'd6, 3'd2, 3'd3, F4,  F6};
      tbl[7] = '{3'd4, F0,   3'd5, F0,   3'd6, 3'd5, 3'd4, 3'd5, F0,  F0};
      tbl[8] = '{3'd7, F1,   3'd6, F2P5, 3'd0, 3'd0, 3'd7, 3'd7, F0,  F2};

      for (int i = 0; i < NR; i++) mreg[i] = '0;
      reset_n = 1'b0; instr_valid = 1'b0; ld_valid = 1'b0;
      instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
      ld_addr = '0; ld_data = '0; rd_addr = '0;

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      chk("rst_busy", vec_t'(busy), vec_t'(0));
      chk("rst_done", vec_t'(done), vec_t'(0));
      chk("rst_vu_op", vec_t'(vu_op), vec_t'(0));
      chk("rst_vu_inK", vec_t'(vu_inK), vec_t'(0));
      chk("rst_ready", vec_t'({instr_ready, ld_ready}), vec_t'(2'b11));
      ld_valid = 1'b1; #1;
      chk("rst_ready_ldv", vec_t'({instr_ready, ld_ready}), vec_t'(2'b01));
      ld_valid = 1'b0;
      @(negedge clock); reset_n = 1'b1;
      for (int r = 0; r < NR; r++) begin
         rd_addr = 3'(r); #1;
         chk($sformatf("rst_reg%0d", r), rd_data, '0);
      end

      // Table-driven single instructions
      for (int i = 0; i < 9; i++) begin
         nm = $sformatf("tbl%0d", i);
         do_load(tbl[i].la, splat(tbl[i].lv));
         do_load(tbl[i].lb, splat(tbl[i].lw));
         run(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, nm);
         chk({nm, "_exp"}, rd_data, splat(tbl[i].exp));
      end

      // Back-to-back: SUB offered while SCALE is executing
      do_load(3'd1, splat(F3)); do_load(3'd2, splat(F4)); do_load(3'd3, splat(F1));
      @(negedge clock);
      offer(3'd3, 3'd1, 3'd1, 3'd1, FM2, n);
      fork
         wait_done(AL, "b2b_scale");
         begin
            @(negedge clock);
            offer(3'd1, 3'd2, 3'd2, 3'd3, F0, n2);
         end
      join
      chk("b2b_wait", vec_t'(n2), vec_t'(AL + 1));
      wait_done(AL, "b2b_sub");
      chk("b2b_r2", rd_data, splat(F3));
      rd_addr = 3'd1; #1;
      chk("b2b_r1", rd_data, splat(FM6));

      // Load and instruction offered together in IDLE
      @(negedge clock);
      ld_valid = 1'b1; ld_addr = 3'd0; ld_data = splat(F1);
      instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd1;
      instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_imm = F0;
      #1;
      chk("prio_ready", vec_t'({instr_ready, ld_ready}), vec_t'(2'b01));
      @(posedge clock); #1;
      ld_valid = 1'b0; mreg[0] = splat(F1);
      #1;
      chk("prio_after", vec_t'({busy, instr_ready}), vec_t'(2'b01));
      offer(3'd0, 3'd1, 3'd0, 3'd0, F0, n);
      chk("prio_wait", vec_t'(n), vec_t'(0));
      wait_done(AL, "prio_add");
      chk("prio_r1", rd_data, splat(F2));

      // Load held during EXEC of an activation
      do_load(3'd6, splat(F2P5)); do_load(3'd3, splat(F1));
      @(negedge clock);
      offer(3'd7, 3'd7, 3'd6, 3'd6, F0, n);
      fork
         wait_done(TL, "ldblk_relu");
         begin
            int k;
            @(negedge clock);
            ld_valid = 1'b1; ld_addr = 3'd3; ld_data = splat(F5);
            rd_addr = 3'd3;
            @(negedge clock); #2;
            chk("ldblk_hold", rd_data, splat(F1));
            k = 1;
            while (!ld_ready && k < 20) begin @(negedge clock); #2; k++; end
            chk("ldblk_wait", vec_t'(k), vec_t'(TL + 1));
            @(posedge clock); #1;
            ld_valid = 1'b0; mreg[3] = splat(F5);
         end
      join
      @(negedge clock); rd_addr = 3'd3; #1;
      chk("ldblk_r3", rd_data, splat(F5));

      // Reset in cycle 2 of an ACT_TANH to r5
      do_load(3'd5, splat(F7)); do_load(3'd1, splat(F1));
      @(negedge clock);
      offer(3'd6, 3'd5, 3'd1, 3'd1, F0, n);
      repeat (3) @(negedge clock);
      #1;
      chk("abort_c2", vec_t'({busy, done}), vec_t'(2'b10));
      reset_n = 1'b0;
      ld_valid = 1'b1; ld_addr = 3'd6; ld_data = splat(F9);
      rd_addr = 3'd5;
      @(negedge clock); #1;
      chk("abort_c3", vec_t'({busy, done, instr_ready, ld_ready}), vec_t'(4'b0001));
      chk("abort_r5_clear", rd_data, '0);
      @(negedge clock); ld_valid = 1'b0;
      @(negedge clock); reset_n = 1'b1;
      sbq.delete();
      for (int i = 0; i < NR; i++) mreg[i] = '0;
      ok = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock); #1;
         if (done || busy) ok = 1'b0;
      end
      chk("abort_no_done", vec_t'(ok), vec_t'(1));
      chk("abort_r5", rd_data, '0);
      rd_addr = 3'd6; #1;
      chk("abort_r6_noload", rd_data, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

endmodule

// File: doc/vec_issue.md
VEC_ISSUE -- requirements
Module: vec_issue

Interface
REQ-001 Parameter WIDTH, default 128: number of 32-bit lanes per vector.
REQ-002 Parameter NUM_REGS, default 8: number of vector registers; power of two, at least 2.
REQ-003 Parameter ARITH_LAT, default 1: execution cycles for ops ADD, SUB, DOT, SCALE, DELTA; at least 1.
REQ-004 Parameter ACT_LAT, default 4: execution cycles for ops ACT_SIGMOID, ACT_TANH, ACT_RELU; at least 1.
REQ-005 clock  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 instr_valid  in  1  instruction offered.
REQ-008 instr_ready  out  1  instruction accepted when instr_valid and instr_ready are both high at a rising edge.
REQ-009 instr_op  in  3  vector-unit op code: ADD=0, SUB=1, DOT=2, SCALE=3, DELTA=4, ACT_SIGMOID=5, ACT_TANH=6, ACT_RELU=7.
REQ-010 instr_rd, instr_rs1, instr_rs2  in  log2(NUM_REGS) each  destination and source register indices.
REQ-011 instr_imm  in  32  IEEE-754 single scalar, sent on vu_inK.
REQ-012 ld_valid  in  1  host vector-register load request.
REQ-013 ld_ready  out  1  load accepted when ld_valid and ld_ready are both high at a rising edge.
REQ-014 ld_addr  in  log2(NUM_REGS); ld_data  in  WIDTH x 32  load target and data.
REQ-015 rd_addr  in  log2(NUM_REGS); rd_data  out  WIDTH x 32  combinational register read-back.
REQ-016 vu_op  out  3  op code driven to the vector unit.
REQ-017 vu_in1, vu_in2  out  WIDTH x 32; vu_inK  out  32  vector-unit operands.
REQ-018 vu_out  in  WIDTH x 32  combinational result from the vector unit.
REQ-019 busy  out  1  high when state is not IDLE.
REQ-020 done  out  1  high exactly during the WRITE cycle.

Function
REQ-021 FSM states: IDLE, EXEC, WRITE.
REQ-022 Each instruction has latency lat: ARITH_LAT for op codes 0-4, ACT_LAT for op codes 5-7.
REQ-023 In IDLE, load has priority: ld_ready=1; instr_ready = !ld_valid; in EXEC and WRITE, ld_ready=0 and instr_ready=0.
REQ-024 On load acceptance, regs[ld_addr] <= ld_data; state stays IDLE.
REQ-025 On instruction acceptance (edge 0): latch op, rd, rs1, rs2 and imm; load counter with lat-1; state <= EXEC.
REQ-026 Numbering: cycle k is the cycle after the k-th edge following edge 0; EXEC occupies cycles 0 through lat-1.
REQ-027 EXEC: if counter==0 then state <= WRITE, else counter decrements by 1.
REQ-028 WRITE occupies cycle lat; regs[rd_q] <= vu_out at edge lat+1; state <= IDLE; instr_ready can be high from cycle lat+1.
REQ-029 Peak throughput is one instruction per lat+2 cycles.
REQ-030 Outputs vu_op=op_q and vu_inK=imm_q are driven from latches; vu_in1=regs[rs1_q] and vu_in2=regs[rs2_q] are combinational.
REQ-031 Operands stay stable from cycle 0 through cycle lat, because loads are blocked while busy.
REQ-032 rd equal to rs1 or rs2 is legal; sources are read before the single write at edge lat+1.
REQ-033 rs1 equal to rs2 is legal.
REQ-034 rd_data=regs[rd_addr] combinationally; a write becomes visible in the cycle after its edge.
REQ-035 Counter width is log2(max(ARITH_LAT, ACT_LAT)) + 1.

Reset
REQ-036 When reset_n is low at an edge: state <= IDLE; counter, op_q, rd_q, rs1_q, rs2_q <= 0; imm_q <= 0.0; all regs <= 0.
REQ-037 Output values at reset: busy=0, done=0, vu_op=0, vu_inK=0, instr_ready=!ld_valid, ld_ready=1.
REQ-038 Reset asserted during EXEC or WRITE aborts the instruction with no register write; done is 0 in the following cycle.
REQ-039 While reset_n is low, load and instruction acceptance are ignored.

Verification
REQ-040 Load r1 with all lanes 1.5 and r2 with all lanes 2.0, then ADD rd=3 rs1=1 rs2=2: done in cycle 1; r3 = 3.5 in all lanes from cycle 2; busy high in cycles 0-1.
REQ-041 Load r1 with all lanes 0.0, then ACT_SIGMOID rd=4 rs1=1: EXEC in cycles 0-3, done in cycle 4, r4 = 0.5 in all lanes; ready stays low in cycles 0-4.
REQ-042 Load r1=3.0, then SCALE rd=1 rs1=1 with imm=-2.0: r1 = -6.0; with loads beforehand r2=4.0 and r3=1.0, a back-to-back SUB rd=2 rs1=2 rs2=3 offered while busy is accepted at the first IDLE cycle and gives r2 = 3.0.
REQ-043 In IDLE, assert ld_valid and instr_valid together: load accepted, instr_ready=0; instruction accepted in the next cycle once ld_valid drops.
REQ-044 Pull reset_n low in cycle 2 of an ACT_TANH to r5 that already holds 7.0: no done pulse; r5 = 0.0 after reset (the reset clear); the instruction's write to r5 never takes place.
REQ-045 Hold ld_valid high during EXEC: ld_ready=0, r-file unchanged; load completes in the first IDLE cycle.
